// File: rtl/grf_pkg.sv
// Shared defaults for the general register file and its pending-write scoreboard.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;
  localparam int REG0_IDX   = 0;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters: issue acceptance, RAW busy flags, sticky underflow error.
// Combinational outputs from registered counters; counters update on the rising edge.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic              i_iss,
  input  logic [ADDR_W-1:0] i_iss_wa,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic              o_iss_ok,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_wb_err
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] IDX0    = ADDR_W'(REG0_IDX);

  logic [CNT_W-1:0] r_cnt [DEPTH];
  logic             r_wb_err;

  logic             w_wr_live;
  logic             w_iss_zero;
  logic             w_iss_dec;
  logic             w_iss_ok;
  logic             w_inc_live;
  logic             w_underflow;
  logic [DEPTH-1:0] w_inc;
  logic [DEPTH-1:0] w_dec;

  always_comb begin
    w_wr_live   = i_we && !(ZERO_REG && (i_wa == IDX0));
    w_iss_zero  = ZERO_REG && (i_iss_wa == IDX0);
    w_iss_dec   = w_wr_live && (i_wa == i_iss_wa) && (r_cnt[i_iss_wa] != '0);
    w_iss_ok    = !res && (w_iss_zero || (r_cnt[i_iss_wa] != CNT_MAX) || w_iss_dec);
    w_inc_live  = i_iss && w_iss_ok && !w_iss_zero;
    w_underflow = w_wr_live && (r_cnt[i_wa] == '0);
    w_inc       = '0;
    w_dec       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_inc[i] = w_inc_live && (i_iss_wa == ADDR_W'(i));
      w_dec[i] = w_wr_live && (i_wa == ADDR_W'(i)) && (r_cnt[i] != '0);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    always_ff @(posedge clk or posedge res) begin
      if (res) begin
        r_cnt[g] <= '0;
      end else if (w_inc[g] && !w_dec[g]) begin
        r_cnt[g] <= r_cnt[g] + CNT_W'(1);
      end else if (w_dec[g] && !w_inc[g]) begin
        r_cnt[g] <= r_cnt[g] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_wb_err <= 1'b0;
    end else if (w_underflow) begin
      r_wb_err <= 1'b1;
    end
  end

  // The last outstanding write being forwarded this cycle clears the hazard early.
  function automatic logic busy_of(input logic [ADDR_W-1:0] ra,
                                   input logic [CNT_W-1:0]  cnt,
                                   input logic              we,
                                   input logic [ADDR_W-1:0] wa);
    logic b;
    b = (cnt != '0);
    if (ZERO_REG && (ra == IDX0)) b = 1'b0;
    if (BYPASS && (cnt == CNT_W'(1)) && we && (wa == ra)) b = 1'b0;
    return b;
  endfunction

  assign o_busy1  = !res && busy_of(i_ra1, r_cnt[i_ra1], i_we, i_wa);
  assign o_busy2  = !res && busy_of(i_ra2, r_cnt[i_ra2], i_we, i_wa);
  assign o_iss_ok = w_iss_ok;
  assign o_wb_err = r_wb_err;

endmodule

// File: rtl/grf_bypass_sb.sv
// General register file, two combinational reads, one write, optional bypass and zero register.
// Reads are zero-latency, writes land on the next edge; stall flags RAW hazards from the scoreboard.
module grf_bypass_sb
  import grf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              iss,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              iss_ok,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic              wb_err
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX0  = ADDR_W'(REG0_IDX);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_live;
  logic              w_iss_ok;
  logic              w_busy1;
  logic              w_busy2;

  assign w_wr_live = we && !(ZERO_REG && (wa == IDX0));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[wa] <= wd;
    end
  end

  assign rd1 = res                           ? '0 :
               (ZERO_REG && (ra1 == IDX0))   ? '0 :
               (BYPASS && we && (wa == ra1)) ? wd : r_regs[ra1];

  assign rd2 = res                           ? '0 :
               (ZERO_REG && (ra2 == IDX0))   ? '0 :
               (BYPASS && we && (wa == ra2)) ? wd : r_regs[ra2];

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .res      (res),
    .i_we     (we),
    .i_wa     (wa),
    .i_iss    (iss),
    .i_iss_wa (iss_wa),
    .i_ra1    (ra1),
    .i_ra2    (ra2),
    .o_iss_ok (w_iss_ok),
    .o_busy1  (w_busy1),
    .o_busy2  (w_busy2),
    .o_wb_err (wb_err)
  );

  assign iss_ok = w_iss_ok;
  assign busy1  = w_busy1;
  assign busy2  = w_busy2;
  assign stall  = !res && (w_busy1 || w_busy2 || (iss && !w_iss_ok));

endmodule
